mod_counter_ud: RTL and testbench

Parametrised modulo up/down counter with synchronous load, configurable lower bound, carry/borrow pulses and registered two-digit BCD output. It is the generic time-field counter of the digital clock: one instance per field (seconds 0-59, minutes 0-59, hours 0-23 or 1-12), cascaded through `cout`/`bout` into `cin`. The load port serves time-setting. The BCD outputs feed the seven-segment driver directly.

---
 rtl/mod_counter_ud.sv | 111 +++++++++++
 tb/tb_mod_counter_ud.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter_ud.sv
// Modulo up/down counter with synchronous load, carry/borrow pulses and registered BCD digits.
// One instance per clock field; cascade by feeding cout (or bout) into the next stage's cin.
module mod_counter_ud #(
  parameter int unsigned COUNT_MAX = 60,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned WIDTH     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cin,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             cout,
  output logic             bout,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(COUNT_MAX - 1);
  localparam logic [WIDTH-1:0] MinVal = WIDTH'(MIN_VAL);
  localparam bit               BcdEn  = (COUNT_MAX <= 100);

  // Tens/ones for 0-99 by repeated compare-and-subtract of ten.
  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    logic [3:0]  t;
    r = 32'(v);
    t = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 32'd10) begin
        r = r - 32'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic [7:0]       bcd_q, bcd_d;
  logic             cout_q, cout_d;
  logic             bout_q, bout_d;
  logic             err_q, err_d;
  logic             below_min;

  // A zero lower bound can never be undershot; skip the always-false compare.
  if (MIN_VAL == 0) begin : g_no_min
    assign below_min = 1'b0;
  end else begin : g_min
    assign below_min = (load_val < MinVal);
  end

  always_comb begin
    count_d = count_q;
    cout_d  = 1'b0;
    bout_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      // Any cin tick in a load cycle is dropped.
      if (below_min || (load_val > MaxVal)) begin
        count_d = MinVal;
        err_d   = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (cin) begin
      if (up) begin
        if (count_q < MaxVal) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = MinVal;
          cout_d  = 1'b1;
        end
      end else begin
        if (count_q > MinVal) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = MaxVal;
          bout_d  = 1'b1;
        end
      end
    end
    bcd_d = BcdEn ? to_bcd(count_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= MinVal;
      bcd_q   <= BcdEn ? to_bcd(MinVal) : 8'h00;
      cout_q  <= 1'b0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bcd_q   <= bcd_d;
      cout_q  <= cout_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign bcd_tens = bcd_q[7:4];
  assign bcd_ones = bcd_q[3:0];
  assign cout     = cout_q;
  assign bout     = bout_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_mod_counter_ud.sv
// Directed bench: a vector table on a 0-59 counter, plus sequences for wrap, 1-12 offset and cascade.
module tb_mod_counter_ud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cin, up, load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic [3:0] bcd_tens, bcd_ones;
  logic       cout, bout, load_err;

  logic       up_m, load_m;
  logic [7:0] load_val_m, count_m;
  logic [3:0] tens_m, ones_m;
  logic       cout_m, bout_m, err_m;

  logic       cin_h, up_h, load_h;
  logic [7:0] load_val_h, count_h;
  logic [3:0] tens_h, ones_h;
  logic       cout_h, bout_h, err_h;

  mod_counter_ud u_sec (
    .clk(clk), .reset(reset), .cin(cin), .up(up), .load(load), .load_val(load_val),
    .count(count), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .cout(cout), .bout(bout), .load_err(load_err)
  );

  mod_counter_ud u_min (
    .clk(clk), .reset(reset), .cin(cout), .up(up_m), .load(load_m), .load_val(load_val_m),
    .count(count_m), .bcd_tens(tens_m), .bcd_ones(ones_m),
    .cout(cout_m), .bout(bout_m), .load_err(err_m)
  );

  mod_counter_ud #(.COUNT_MAX(13), .MIN_VAL(1), .WIDTH(8)) u_hr (
    .clk(clk), .reset(reset), .cin(cin_h), .up(up_h), .load(load_h), .load_val(load_val_h),
    .count(count_h), .bcd_tens(tens_h), .bcd_ones(ones_h),
    .cout(cout_h), .bout(bout_h), .load_err(err_h)
  );

  typedef struct {
    logic       rst, ld, ci, u;
    logic [7:0] lv;
    logic [7:0] ec;
    logic [3:0] et, eo;
    logic       ecout, ebout, eerr;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ld, logic ci, logic u, logic [7:0] lv,
                              logic [7:0] ec, logic [3:0] et, logic [3:0] eo,
                              logic ecout, logic ebout, logic eerr);
    vec_t v;
    v.rst = rst; v.ld = ld; v.ci = ci; v.u = u; v.lv = lv;
    v.ec = ec; v.et = et; v.eo = eo; v.ecout = ecout; v.ebout = ebout; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cin = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'd0;
    up_m = 1'b1; load_m = 1'b0; load_val_m = 8'd0;
    cin_h = 1'b0; up_h = 1'b1; load_h = 1'b0; load_val_h = 8'd0;

    //              rst ld ci u  lv    cnt  T  O  co bo er
    vecs.push_back(mk(1, 0, 0, 1, 8'd0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 8'd0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'd0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'd0,   1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,  59, 5, 9, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,  59, 5, 9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'd0,   0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'd45, 45, 4, 5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'd60,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 8'd59, 59, 5, 9, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 8'd45, 45, 4, 5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'd0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'd0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 8'd255, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 8'd59, 59, 5, 9, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 8'd0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd37, 37, 3, 7, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,  36, 3, 6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'd0,  37, 3, 7, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'd0,  37, 3, 7, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'd10, 10, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,   9, 0, 9, 0, 0, 0));

    tick();
    foreach (vecs[i]) begin
      reset = vecs[i].rst; load = vecs[i].ld; cin = vecs[i].ci; up = vecs[i].u;
      load_val = vecs[i].lv;
      tick();
      chk($sformatf("vec%0d count/bcd", i), {count, bcd_tens, bcd_ones},
          {vecs[i].ec, vecs[i].et, vecs[i].eo});
      chk($sformatf("vec%0d pulses", i), {cout, bout, load_err},
          {vecs[i].ecout, vecs[i].ebout, vecs[i].eerr});
    end

    // Two reset cycles; also checks the 1-12 instance resets to its lower bound.
    reset = 1'b1; load = 1'b0; cin = 1'b0; up = 1'b1;
    tick();
    tick();
    chk("reset sec", {count, bcd_tens, bcd_ones, cout, bout, load_err}, 19'h0);
    chk("reset hr count/bcd", {count_h, tens_h, ones_h}, {8'd1, 4'd0, 4'd1});
    chk("reset hr pulses", {cout_h, bout_h, err_h}, 3'b000);

    // Sustained up-count over two full periods.
    reset = 1'b0; cin = 1'b1; up = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick();
      chk($sformatf("upwrap count %0d", i), count, (i + 1) % 60);
      chk($sformatf("upwrap cout %0d", i), cout, ((i + 1) % 60) == 0);
      if (i == 58) chk("upwrap bcd at 59", {bcd_tens, bcd_ones}, {4'd5, 4'd9});
    end
    cin = 1'b0;

    // Offset field: down-wrap from 1 to 12, then up-wrap back to 1.
    cin_h = 1'b1; up_h = 1'b0;
    tick();
    chk("hr downwrap count/bcd", {count_h, tens_h, ones_h}, {8'd12, 4'd1, 4'd2});
    chk("hr downwrap pulses", {cout_h, bout_h}, 2'b01);
    cin_h = 1'b0;
    tick();
    chk("hr bout one cycle", {count_h, bout_h}, {8'd12, 1'b0});
    cin_h = 1'b1; up_h = 1'b1;
    tick();
    chk("hr upwrap", {count_h, cout_h, bout_h}, {8'd1, 1'b1, 1'b0});
    cin_h = 1'b0; load_h = 1'b1; load_val_h = 8'd0;
    tick();
    chk("hr load below min", {count_h, err_h}, {8'd1, 1'b1});
    load_val_h = 8'd13;
    tick();
    chk("hr load above max", {count_h, err_h}, {8'd1, 1'b1});
    load_val_h = 8'd7;
    tick();
    chk("hr load 7", {count_h, tens_h, ones_h, err_h}, {8'd7, 4'd0, 4'd7, 1'b0});
    load_h = 1'b0;

    // Cascade 59:59 -> 00:00 with one cycle of skew.
    load = 1'b1; load_val = 8'd59; load_m = 1'b1; load_val_m = 8'd59; cin = 1'b0;
    tick();
    chk("cascade preload", {count, count_m}, {8'd59, 8'd59});
    load = 1'b0; load_m = 1'b0; cin = 1'b1; up = 1'b1;
    tick();
    chk("cascade sec wrap", {count, cout, count_m}, {8'd0, 1'b1, 8'd59});
    cin = 1'b0;
    tick();
    chk("cascade min wrap", {count_m, tens_m, ones_m, cout_m, cout}, {8'd0, 4'd0, 4'd0, 2'b10});
    tick();
    chk("cascade min cout one cycle", {count_m, cout_m}, {8'd0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
